rr_timeout_arbiter: RTL

Parametrised N-port round-robin arbiter with per-port programmable hold timeout, for router output-port allocation. It generalises the fixed five-port L/N/E/W/S arbiter in three ways: the port count and length width are parameters, round-robin priority rotates from the last owner instead of a fixed order per state, and there is an explicit timeout indication. Each port's hold limit is latched from the length field of that port's header flit. It sits between the input-buffer request logic and the crossbar select.

---
 rtl/rr_timeout_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: N-port round-robin arbiter for router output-port
// allocation. Priority rotates from the last owner. Each port has a hold
// limit, loaded from the length field of its header flits, after which the
// grant is force-released with a one-cycle timeout pulse.
//
// Handshake: req_i[i] is a level request. grant_o[i] is a registered
// acknowledgement and stays high for as long as port i owns the output.
// The owner keeps the grant until one of three things happens: it drops
// req_i, its hold limit expires, or reset is asserted. Requests from other
// ports never preempt the owner early.
module rr_timeout_arbiter #(
    parameter int               NPORTS    = 5,
    parameter int               LEN_W     = 12,
    parameter int               FID_W     = 3,
    parameter logic [FID_W-1:0] HEADER_ID = 3'b001
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NPORTS-1:0]          req_i,
    input  logic [NPORTS*FID_W-1:0]    flit_id_i,
    input  logic [NPORTS*LEN_W-1:0]    length_i,
    output logic [NPORTS-1:0]          grant_o,
    output logic                       grant_valid_o,
    output logic [$clog2(NPORTS)-1:0]  grant_id_o,
    output logic [NPORTS-1:0]          timeout_o,
    // Debug visibility of the FSM state and the hold counter.
    output logic [0:0]                 dbg_state_o,
    output logic [LEN_W-1:0]           dbg_cnt_o
);

    localparam int IDW = $clog2(NPORTS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [IDW-1:0]    ptr_q,      ptr_d;
    logic [LEN_W-1:0]  cnt_q,      cnt_d;
    logic [NPORTS-1:0] grant_q,    grant_d;
    logic [NPORTS-1:0] timeout_q,  timeout_d;
    logic [LEN_W-1:0]  lim_q [NPORTS];

    logic [IDW-1:0]    search_from;
    logic [IDW:0]      pick;
    logic              pick_found;
    logic [IDW-1:0]    pick_id;
    logic [LEN_W-1:0]  owner_lim;
    logic              owner_req;
    logic              limit_hit;

    // Returns {found, index} of the first requester after 'last', in the
    // order last+1, last+2, ..., last (modulo NPORTS). The loop runs from
    // the farthest candidate to the nearest so that the nearest one wins.
    function automatic logic [IDW:0] rr_search(input logic [NPORTS-1:0] r,
                                               input logic [IDW-1:0]    last);
        logic [IDW:0]   res;
        logic [IDW-1:0] sel;
        int             idx;
        res = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NPORTS) begin
                idx = idx - NPORTS;
            end
            sel = IDW'(idx);
            if (r[sel]) begin
                res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    // In BUSY the owner and ptr coincide; in IDLE ptr holds the last owner.
    assign search_from = (state_q == ST_BUSY) ? grant_id_q : ptr_q;
    assign pick        = rr_search(req_i, search_from);
    assign pick_found  = pick[IDW];
    assign pick_id     = pick[IDW-1:0];
    assign owner_lim   = lim_q[grant_id_q];
    assign owner_req   = req_i[grant_id_q];
    // The compare uses the limit latched before this edge, so a header
    // arriving on the owner in the same cycle only affects later cycles.
    assign limit_hit   = (owner_lim != '0) && (cnt_q == owner_lim - LEN_W'(1));

    // Next-state arbitration: idle pick, release on drop, forced release on limit, or hold.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        timeout_d  = '0;
        grant_d    = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    state_d    = ST_BUSY;
                    grant_id_d = pick_id;
                    ptr_d      = pick_id;
                end
            end
            default: begin
                if (!owner_req) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        grant_id_d = pick_id;
                        ptr_d      = pick_id;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_id_d = '0;
                    end
                end else if (limit_hit) begin
                    // The owner is still requesting, so the search always
                    // finds someone; the owner itself comes last in the order.
                    timeout_d[grant_id_q] = 1'b1;
                    cnt_d      = '0;
                    grant_id_d = pick_id;
                    ptr_d      = pick_id;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
        endcase
        if (state_d == ST_BUSY) begin
            grant_d[grant_id_d] = 1'b1;
        end
    end

    // Arbitration state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            ptr_q      <= IDW'(NPORTS - 1);
            cnt_q      <= '0;
            grant_q    <= '0;
            timeout_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
        end
    end

    // Per-port hold limits, latched from every header flit whether granted or not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NPORTS; i++) begin
                lim_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (flit_id_i[i*FID_W +: FID_W] == HEADER_ID) begin
                    lim_q[i] <= length_i[i*LEN_W +: LEN_W];
                end
            end
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = state_q[0];
    assign grant_id_o    = grant_id_q;
    assign timeout_o     = timeout_q;
    assign dbg_state_o   = state_q;
    assign dbg_cnt_o     = cnt_q;

endmodule
